// File: rtl/qam_sym_scheduler.sv
// Purpose: paces payload bits into 1..4-bit QAM symbol indices at a programmable symbol rate (optional stats: QAM_SCHED_STATS_EN).
// Latency: symbol strobe/bits and underrun are registered one cycle after the period tick; in_ready is combinational.
// Backpressure: in_ready only in RUN with <=4 buffered bits; a tick with too few bits in RUN raises underrun.
module qam_sym_scheduler #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] sym_div,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             sym_select,
   output logic [3:0]       sym_bits,
   output logic             underrun,
   output logic             busy
`ifdef QAM_SCHED_STATS_EN
   ,
   output logic [15:0]      sym_count
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [11:0]      buf_q, buf_d;
   logic [3:0]       fill_q, fill_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             sym_select_q, sym_select_d;
   logic [3:0]       sym_bits_q, sym_bits_d;
   logic             underrun_q, underrun_d;

   logic             start_run;
   logic             enter_run;
   logic             tick;
   logic             emit;
   logic             pad;
   logic             accept;
   logic [3:0]       k4;
   logic [3:0]       sym_val;
   logic [11:0]      buf_shift;
   logic [3:0]       fill_rem;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: enable wins over draining so buffered bits survive a quick re-enable
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (enable) state_d = ST_RUN;
         ST_RUN:   if (!enable) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (enable) begin
               state_d = ST_RUN;
            end else if (fill_q == 4'd0) begin
               state_d = ST_IDLE;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: input acceptance only while running with room for a full byte
   always_comb begin
      in_ready = (state_q == ST_RUN) && (fill_q <= 4'd4);
      busy     = (state_q != ST_IDLE);
   end

   // Symbol datapath: period tick, symbol extraction and buffer update
   always_comb begin
      start_run = (state_q == ST_IDLE) && (state_d == ST_RUN);
      enter_run = (state_q != ST_RUN) && (state_d == ST_RUN);
      k4        = {2'b00, mode_q} + 4'd1;
      tick      = busy && (cnt_q == div_q);
      accept    = in_valid && in_ready;
      // Bits below the fill level are always zero, so the top nibble is already LSB-padded
      sym_val   = buf_q[11:8] >> (4'd4 - k4);
      pad       = tick && (state_q == ST_DRAIN) && (fill_q != 4'd0) && (fill_q < k4);
      emit      = (tick && (fill_q >= k4)) || pad;

      buf_shift = buf_q;
      fill_rem  = fill_q;
      if (pad) begin
         buf_shift = 12'd0;
         fill_rem  = 4'd0;
      end else if (emit) begin
         buf_shift = buf_q << k4;
         fill_rem  = fill_q - k4;
      end

      // fill_rem <= 4 whenever a byte is accepted, so the byte always fits below the remainder
      buf_d  = buf_shift;
      fill_d = fill_rem;
      if (accept) begin
         buf_d  = buf_shift | ({in_data, 4'b0000} >> fill_rem);
         fill_d = fill_rem + 4'd8;
      end

      cnt_d = cnt_q;
      if (enter_run || !busy) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      mode_d = mode_q;
      div_d  = div_q;
      if (start_run) begin
         mode_d = mode;
         div_d  = sym_div;
      end

      sym_select_d = emit;
      sym_bits_d   = emit ? sym_val : sym_bits_q;
      underrun_d   = tick && (state_q == ST_RUN) && (fill_q < k4);
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_q        <= 12'd0;
         fill_q       <= 4'd0;
         cnt_q        <= '0;
         mode_q       <= 2'd0;
         div_q        <= '0;
         sym_select_q <= 1'b0;
         sym_bits_q   <= 4'd0;
         underrun_q   <= 1'b0;
      end else begin
         buf_q        <= buf_d;
         fill_q       <= fill_d;
         cnt_q        <= cnt_d;
         mode_q       <= mode_d;
         div_q        <= div_d;
         sym_select_q <= sym_select_d;
         sym_bits_q   <= sym_bits_d;
         underrun_q   <= underrun_d;
      end
   end

   assign sym_select = sym_select_q;
   assign sym_bits   = sym_bits_q;
   assign underrun   = underrun_q;

`ifdef QAM_SCHED_STATS_EN
   logic [15:0] sym_cnt_q, sym_cnt_d;

   // Emitted-symbol counter, saturating, restarted with each new run
   always_comb begin
      sym_cnt_d = sym_cnt_q;
      if (start_run) begin
         sym_cnt_d = 16'd0;
      end else if (emit && (sym_cnt_q != 16'hFFFF)) begin
         sym_cnt_d = sym_cnt_q + 16'd1;
      end
   end

   // Stats register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sym_cnt_q <= 16'd0;
      end else begin
         sym_cnt_q <= sym_cnt_d;
      end
   end

   assign sym_count = sym_cnt_q;
`endif

endmodule

// File: tb/tb_qam_sym_scheduler.sv
// Purpose: directed self-checking bench for qam_sym_scheduler.
// Latency: outputs sampled on the falling edge or 1 time unit after the rising edge.
// Backpressure: bytes are offered with in_valid and held until in_ready is seen.
module tb_qam_sym_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [1:0] mode;
   logic [7:0] sym_div;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       sym_select;
   logic [3:0] sym_bits;
   logic       underrun;
   logic       busy;
`ifdef QAM_SCHED_STATS_EN
   logic [15:0] sym_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [3:0] sq[$];
   int         sc[$];
   int         uq[$];

   qam_sym_scheduler #(.DIV_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .mode       (mode),
      .sym_div    (sym_div),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sym_select (sym_select),
      .sym_bits   (sym_bits),
      .underrun   (underrun),
      .busy       (busy)
`ifdef QAM_SCHED_STATS_EN
      ,
      .sym_count  (sym_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every strobe and underrun with its cycle number
   always @(negedge clk) begin
      if (rst) begin
         if (sym_select) begin
            sq.push_back(sym_bits);
            sc.push_back(cyc);
         end
         if (underrun) uq.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] symq(input int i);
      return (i < sq.size()) ? 32'(sq[i]) : 32'hDEAD;
   endfunction

   function automatic int scq(input int i);
      return (i < sc.size()) ? sc[i] : -1000;
   endfunction

   function automatic int uqq(input int i);
      return (i < uq.size()) ? uq[i] : -1000;
   endfunction

   task automatic clr_q();
      sq.delete();
      sc.delete();
      uq.delete();
   endtask

   task automatic start_run(input logic [1:0] m, input logic [7:0] d);
      @(posedge clk);
      #1;
      mode    = m;
      sym_div = d;
      enable  = 1'b1;
      clr_q();
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic ok;
      ok       = 1'b0;
      in_data  = b;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
      in_valid = 1'b0;
      chk("send_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_syms(input int n, input int budget);
      for (int i = 0; i < budget && sq.size() < n; i++) @(negedge clk);
      chk("sym_arrival", 32'(sq.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy; i++) @(negedge clk);
      chk("idle_reached", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp30[8];
      rst      = 1'b0;
      enable   = 1'b0;
      mode     = 2'd0;
      sym_div  = 8'd0;
      in_data  = 8'd0;
      in_valid = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sym_select", 32'(sym_select), 32'd0);
      chk("rst_sym_bits",   32'(sym_bits),   32'd0);
      chk("rst_underrun",   32'(underrun),   32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_in_ready",   32'(in_ready),   32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_no_busy", 32'(busy), 32'd0);

      // 2-bit symbols every 4 cycles from 0xB4, then periodic underrun
      start_run(2'd1, 8'd3);
      send_byte(8'hB4);
      wait_syms(4, 40);
      chk("t29_sym0", symq(0), 32'd2);
      chk("t29_sym1", symq(1), 32'd3);
      chk("t29_sym2", symq(2), 32'd1);
      chk("t29_sym3", symq(3), 32'd0);
      for (int i = 0; i < 3; i++) chk("t29_gap", 32'(scq(i + 1) - scq(i)), 32'd4);
      for (int i = 0; i < 40 && uq.size() < 2; i++) @(negedge clk);
      chk("t29_ur_first", 32'(uqq(0) - scq(3)), 32'd4);
      chk("t29_ur_gap",   32'(uqq(1) - uqq(0)), 32'd4);
      enable = 1'b0;
      wait_idle(40);

      // 3-bit symbols at full rate across three back-to-back bytes
      start_run(2'd2, 8'd0);
      send_byte(8'hFF);
      send_byte(8'h00);
      send_byte(8'hAA);
      wait_syms(8, 40);
      exp30 = '{4'd7, 4'd7, 4'd6, 4'd0, 4'd0, 4'd2, 4'd5, 4'd2};
      for (int i = 0; i < 8; i++) chk("t30_sym", symq(i), 32'(exp30[i]));
      enable = 1'b0;
      wait_idle(40);

      // Drain with LSB padding of the final partial symbol
      start_run(2'd2, 8'd1);
      send_byte(8'hA5);
      enable = 1'b0;
      wait_syms(3, 40);
      wait_idle(40);
      chk("t31_sym0",  symq(0), 32'd5);
      chk("t31_sym1",  symq(1), 32'd1);
      chk("t31_sym2",  symq(2), 32'd2);
      chk("t31_count", 32'(sq.size()), 32'd3);
      chk("t31_no_ur", 32'(uq.size()), 32'd0);
      chk("t31_in_ready_idle", 32'(in_ready), 32'd0);

      // 4-bit symbols with in_valid held; in_ready tracks the fill level
      start_run(2'd3, 8'd1);
      in_data  = 8'h12;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("t32_rdy_fill0", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk("t32_rdy_fill8", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("t32_first_strobe", 32'(sym_select), 32'd1);
      chk("t32_first_bits",   32'(sym_bits),   32'd1);
      chk("t32_rdy_fill4",    32'(in_ready),   32'd1);
      in_data = 8'h34;
      @(posedge clk); #1;
      chk("t32_rdy_fill12", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("t32_rdy_fill8b", 32'(in_ready), 32'd0);
      wait_syms(4, 40);
      chk("t32_sym0", symq(0), 32'd1);
      chk("t32_sym1", symq(1), 32'd2);
      chk("t32_sym2", symq(2), 32'd3);
      chk("t32_sym3", symq(3), 32'd4);
      enable = 1'b0;
      wait_idle(40);

      // Asynchronous reset mid-stream with 6 bits buffered
      start_run(2'd1, 8'd3);
      send_byte(8'hB4);
      wait_syms(1, 20);
      chk("t33_pre_sym", symq(0), 32'd2);
      rst    = 1'b0;
      enable = 1'b0;
      #1;
      chk("t33_sym_select", 32'(sym_select), 32'd0);
      chk("t33_sym_bits",   32'(sym_bits),   32'd0);
      chk("t33_underrun",   32'(underrun),   32'd0);
      chk("t33_busy",       32'(busy),       32'd0);
      chk("t33_in_ready",   32'(in_ready),   32'd0);
      @(negedge clk);
      rst = 1'b1;
      clr_q();
      repeat (16) @(negedge clk);
      chk("t33_no_strobe", 32'(sq.size()), 32'd0);
      chk("t33_no_ur",     32'(uq.size()), 32'd0);
      chk("t33_still_idle", 32'(busy),     32'd0);
      start_run(2'd1, 8'd3);
      send_byte(8'h40);
      wait_syms(2, 40);
      chk("t33_fresh_sym0", symq(0), 32'd1);
      chk("t33_fresh_sym1", symq(1), 32'd0);
      enable = 1'b0;
      wait_idle(40);

      // Mode change while busy is ignored until the next start from idle
      start_run(2'd1, 8'd1);
      send_byte(8'hB4);
      mode = 2'd3;
      wait_syms(4, 40);
      chk("t34_sym0", symq(0), 32'd2);
      chk("t34_sym1", symq(1), 32'd3);
      chk("t34_sym2", symq(2), 32'd1);
      chk("t34_sym3", symq(3), 32'd0);
      enable = 1'b0;
      wait_idle(40);
      start_run(2'd3, 8'd1);
      send_byte(8'hB4);
      wait_syms(2, 40);
      chk("t34_new_sym0", symq(0), 32'd11);
      chk("t34_new_sym1", symq(1), 32'd4);
`ifdef QAM_SCHED_STATS_EN
      chk("t34_sym_count", 32'(sym_count), 32'd2);
`endif
      enable = 1'b0;
      wait_idle(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/qam_sym_scheduler.md
QAM_SYM_SCHEDULER -- requirements
Module: qam_sym_scheduler

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the symbol-period divider.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port enable  input  1  level, high = run scheduler, low = drain and stop.
REQ-005 SHALL have port mode  input  2  bits per symbol minus one: 0=1b, 1=2b, 2=3b, 3=4b.
REQ-006 SHALL have port sym_div  input  DIV_W  symbol period minus one, in clk cycles.
REQ-007 SHALL have port in_data  input  8  payload byte, MSB transmitted first.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  byte accepted on cycles where in_valid and in_ready are both high.
REQ-010 SHALL have port sym_select  output  1  one-cycle strobe to the mapper's select input.
REQ-011 SHALL have port sym_bits  output  4  symbol index, right-justified, unused upper bits zero.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse, symbol slot missed for lack of data.
REQ-013 SHALL have port busy  output  1  high in RUN or DRAIN.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when the bit buffer is empty.
REQ-015 SHALL latch mode and sym_div on the IDLE->RUN transition; changes while busy are ignored.
REQ-016 SHALL hold a 12-bit bit buffer with fill count 0..12, bits consumed MSB-first.
REQ-017 SHALL drive in_ready = (state==RUN) and (fill<=4), combinationally.
REQ-018 SHALL append an accepted byte behind the bits remaining after any same-cycle symbol consumption; fill_next = fill - k(if emitted) + 8(if accepted).
REQ-019 SHALL run a period counter in RUN/DRAIN, cleared to 0 on entering RUN, producing a tick when count==latched sym_div and wrapping to 0; sym_div=0 gives a tick every cycle.
REQ-020 SHALL, on a tick with fill>=k, register sym_bits = top k buffer bits and sym_select=1 for exactly one cycle at the next edge.
REQ-021 SHALL, on a tick in RUN with fill<k, emit no symbol and register underrun=1 for one cycle.
REQ-022 SHALL, on a tick in DRAIN with 0<fill<k, emit the remaining bits zero-padded on the LSB side to k bits, then empty the buffer.
REQ-023 SHALL never assert underrun in DRAIN or IDLE.
REQ-024 SHALL return enable high during DRAIN to RUN without discarding buffered bits, re-latching mode and sym_div only from IDLE.

Reset
REQ-025 SHALL, while rst=0, force state IDLE, fill=0, period count 0, sym_select=0, sym_bits=0, underrun=0, busy=0, in_ready=0.
REQ-026 SHALL discard all buffered bits on reset asserted mid-operation; first activity after release requires enable=1 from IDLE.

Configuration
REQ-027 SHALL, with macro QAM_SCHED_STATS_EN defined, add output sym_count (16 bits) counting emitted symbols, saturating at 0xFFFF, cleared by reset and on IDLE->RUN.
REQ-028 SHALL, without QAM_SCHED_STATS_EN, omit the sym_count port and its counter; all other behaviour identical.

Verification
REQ-029 SHALL test: mode=1, sym_div=3, one byte 0xB4, enable held -> sym_bits 2,3,1,0, strobes 4 cycles apart, then underrun pulses every 4 cycles.
REQ-030 SHALL test: mode=2, sym_div=0, bytes 0xFF,0x00,0xAA back-to-back -> sym_bits 7,7,6,0,0,2,5,2 with no underrun once data flows.
REQ-031 SHALL test: mode=2, byte 0xA5, enable dropped after acceptance -> 5,1, then padded 2, busy falls, state IDLE, no underrun.
REQ-032 SHALL test: mode=3, sym_div=1, in_valid held high with 0x12,0x34 -> sym_bits 1,2,3,4; in_ready low whenever fill>4.
REQ-033 SHALL test: rst pulsed low mid-stream with fill=6 -> all outputs zero immediately (asynchronous), no strobe after release until enable re-asserted.
REQ-034 SHALL test: mode changed 1->3 while busy -> symbols keep 2-bit grouping until IDLE and restart.
